// File: rtl/hack_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hack_seq_ctrl
// Purpose  : Multi-cycle control sequencer for a Hack-style 16-bit datapath.
//            Fetches an instruction over an imem handshake, latches it into
//            ir, then steps it through DECODE / EXEC / WB and drives the
//            register load strobes, operand/input mux selects, PC control and
//            the dmem handshake. A stalled handshake lands in a sticky FAULT.
// Ports    : clk, rst_n           - clock, async active-low reset
//            instr, imem_req/ack  - instruction fetch handshake
//            dmem_req/we/ack      - data memory handshake (we=1 write)
//            zr, ng               - ALU zero / negative flags
//            ir                   - latched instruction register
//            a_src_alu, am_sel    - A input mux / ALU y operand select
//            load_a, load_d       - A / D register load strobes
//            load_pc, inc_pc      - PC jump / increment strobes
//            state, fault         - debug state, sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module hack_seq_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic        zr,
  input  logic        ng,
  output logic [15:0] ir,
  output logic        a_src_alu,
  output logic        am_sel,
  output logic        load_a,
  output logic        load_d,
  output logic        load_pc,
  output logic        inc_pc,
  output logic [2:0]  state,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             acked;     // a relevant ack completed the current request
  logic             req_any;   // some request is being held this cycle
  logic             timed_out;
  logic             is_c;
  logic             uses_m;
  logic             jump;
  logic             wb_exit;

  assign is_c      = ir[15];
  assign uses_m    = ir[15] & ir[12];
  assign jump      = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);
  assign timed_out = (wait_cnt == TIMEOUT_CNT);
  assign state     = cur_state;
  assign fault     = (cur_state == S_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      ir        <= 16'h0000;
      wait_cnt  <= '0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_FETCH && imem_ack) begin
        ir <= instr;
      end
      // Any state change enters a fresh wait, so the count restarts there.
      if (nxt_state != cur_state || acked) begin
        wait_cnt <= '0;
      end else if (req_any) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nxt_state = cur_state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    a_src_alu = 1'b0;
    am_sel    = 1'b0;
    load_a    = 1'b0;
    load_d    = 1'b0;
    load_pc   = 1'b0;
    inc_pc    = 1'b0;
    acked     = 1'b0;
    req_any   = 1'b0;
    wb_exit   = 1'b0;
    // Outputs are gated by rst_n so a reset drops requests and strobes
    // without waiting for a clock edge.
    if (rst_n) begin
      case (cur_state)
        S_FETCH: begin
          imem_req = 1'b1;
          req_any  = 1'b1;
          if (imem_ack) begin
            acked     = 1'b1;
            nxt_state = S_DECODE;
          end else if (timed_out) begin
            nxt_state = S_FAULT;
          end
        end
        S_DECODE: begin
          nxt_state = S_EXEC;
        end
        S_EXEC: begin
          am_sel = uses_m;
          if (uses_m) begin
            dmem_req = 1'b1;
            req_any  = 1'b1;
            if (dmem_ack) begin
              acked     = 1'b1;
              nxt_state = S_WB;
            end else if (timed_out) begin
              nxt_state = S_FAULT;
            end
          end else begin
            nxt_state = S_WB;
          end
        end
        S_WB: begin
          am_sel = uses_m;
          if (!is_c) begin
            load_a    = 1'b1;
            inc_pc    = 1'b1;
            nxt_state = S_FETCH;
          end else begin
            wb_exit = 1'b1;
            if (ir[3]) begin
              dmem_req = 1'b1;
              dmem_we  = 1'b1;
              req_any  = 1'b1;
              wb_exit  = dmem_ack;
              acked    = dmem_ack;
              if (!dmem_ack && timed_out) begin
                nxt_state = S_FAULT;
              end
            end
            // Strobes and the jump decision belong to the exit cycle only,
            // using the flags present in that cycle.
            if (wb_exit) begin
              a_src_alu = 1'b1;
              load_a    = ir[5];
              load_d    = ir[4];
              load_pc   = jump;
              inc_pc    = ~jump;
              nxt_state = S_FETCH;
            end
          end
        end
        S_FAULT: begin
          nxt_state = S_FAULT;
        end
        default: begin
          nxt_state = S_FAULT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hack_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_seq_ctrl
// Purpose  : Self-checking bench for hack_seq_ctrl. Each instruction is run
//            as a transaction: the bench picks ack delays and flags, derives
//            the expected phase lengths, strobes and jump outcome from the
//            instruction fields, and checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_seq_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        zr = 1'b0;
  logic        ng = 1'b0;
  logic [15:0] ir;
  logic        a_src_alu;
  logic        am_sel;
  logic        load_a;
  logic        load_d;
  logic        load_pc;
  logic        inc_pc;
  logic [2:0]  state;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hack_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .zr(zr), .ng(ng), .ir(ir),
    .a_src_alu(a_src_alu), .am_sel(am_sel),
    .load_a(load_a), .load_d(load_d), .load_pc(load_pc), .inc_pc(inc_pc),
    .state(state), .fault(fault)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe vector order: {load_a, load_d, load_pc, inc_pc}
  function automatic logic [3:0] strobes();
    return {load_a, load_d, load_pc, inc_pc};
  endfunction

  // Called at a negedge; leaves the bench at a negedge with reset released.
  task automatic do_reset();
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_fault", 16'(fault), 16'd0);
    chk("rst_imem_req", 16'(imem_req), 16'd0);
    chk("rst_dmem_req", 16'(dmem_req), 16'd0);
    chk("rst_strobes", 16'(strobes()), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One complete instruction, starting and ending at a negedge in FETCH.
  // fd/rd/wd: wait cycles before the fetch / M-read / M-write ack.
  task automatic do_instr(input logic [15:0] op, input int fd, input int rd,
                          input int wd, input logic zf, input logic nf);
    logic c_instr, uses_m, wr_m, jmp, last;
    logic [3:0] exp_s;
    int pulses, n;
    c_instr = op[15];
    uses_m  = op[15] & op[12];
    wr_m    = op[15] & op[3];
    jmp     = c_instr & ((op[2] & nf) | (op[1] & zf) | (op[0] & ~nf & ~zf));
    pulses  = 0;
    // FETCH
    for (int k = 0; k <= fd; k++) begin
      instr    = (k == fd) ? op : 16'($urandom);
      imem_ack = (k == fd);
      dmem_ack = 1'($urandom);
      zr = 1'($urandom); ng = 1'($urandom);
      #1;
      chk("fetch_state", 16'(state), 16'd0);
      chk("fetch_imem_req", 16'(imem_req), 16'd1);
      chk("fetch_dmem_req", 16'(dmem_req), 16'd0);
      chk("fetch_strobes", 16'(strobes()), 16'd0);
      @(negedge clk);
    end
    chk("ir_latched", ir, op);
    // DECODE (spurious acks must be ignored)
    instr = 16'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
    #1;
    chk("dec_state", 16'(state), 16'd1);
    chk("dec_reqs", 16'({imem_req, dmem_req}), 16'd0);
    chk("dec_strobes", 16'(strobes()), 16'd0);
    chk("dec_am_sel", 16'(am_sel), 16'd0);
    @(negedge clk);
    // EXEC
    n = uses_m ? rd + 1 : 1;
    for (int k = 0; k < n; k++) begin
      imem_ack = 1'($urandom);
      dmem_ack = uses_m ? (k == rd) : 1'($urandom);
      #1;
      chk("exec_state", 16'(state), 16'd2);
      chk("exec_imem_req", 16'(imem_req), 16'd0);
      chk("exec_dmem_req", 16'(dmem_req), 16'(uses_m));
      if (uses_m) chk("exec_dmem_we", 16'(dmem_we), 16'd0);
      chk("exec_am_sel", 16'(am_sel), 16'(uses_m));
      chk("exec_strobes", 16'(strobes()), 16'd0);
      @(negedge clk);
    end
    chk("ir_held", ir, op);
    // WB
    n = wr_m ? wd + 1 : 1;
    for (int k = 0; k < n; k++) begin
      last     = (k == n - 1);
      imem_ack = 1'($urandom);
      dmem_ack = wr_m ? last : 1'($urandom);
      zr = last ? zf : 1'($urandom);
      ng = last ? nf : 1'($urandom);
      #1;
      if (!last)        exp_s = 4'b0000;
      else if (!c_instr) exp_s = 4'b1001;
      else              exp_s = {op[5], op[4], jmp, ~jmp};
      chk("wb_state", 16'(state), 16'd3);
      chk("wb_imem_req", 16'(imem_req), 16'd0);
      chk("wb_dmem_req", 16'(dmem_req), 16'(wr_m));
      if (wr_m) chk("wb_dmem_we", 16'(dmem_we), 16'd1);
      chk("wb_am_sel", 16'(am_sel), 16'(uses_m));
      chk("wb_strobes", 16'(strobes()), 16'(exp_s));
      if (last && (!c_instr || op[5])) chk("wb_a_src_alu", 16'(a_src_alu), 16'(c_instr));
      pulses += int'(load_pc) + int'(inc_pc);
      @(negedge clk);
    end
    chk("pc_pulses", 16'(pulses), 16'd1);
    chk("back_to_fetch", 16'(state), 16'd0);
  endtask

  initial begin
    logic [15:0] op;
    logic [15:0] prev_ir;
    int d0, d1, d2;
    @(negedge clk);
    do_reset();

    // Directed cases
    do_instr(16'h0005, 0, 0, 0, 1'b0, 1'b0);   // A-instruction, 4 cycles
    do_instr(16'hFC10, 0, 3, 0, 1'b0, 1'b0);   // D=M, read waits 3
    do_instr(16'hE308, 0, 0, 2, 1'b0, 1'b0);   // M=D, write waits 2
    do_instr(16'hE301, 0, 0, 0, 1'b0, 1'b0);   // JGT taken
    do_instr(16'hE301, 0, 0, 0, 1'b1, 1'b0);   // JGT not taken
    do_instr(16'hE307, 0, 0, 0, 1'b0, 1'b0);   // JMP
    do_instr(16'hE307, 0, 0, 0, 1'b1, 1'b0);
    do_instr(16'hE307, 0, 0, 0, 1'b0, 1'b1);
    do_instr(16'hF038, TIMEOUT, TIMEOUT, TIMEOUT, 1'b0, 1'b1); // acks at count limit

    // Randomized instructions
    for (int i = 0; i < 40; i++) begin
      op = 16'($urandom);
      if ($urandom_range(0, 3) == 0) op[15] = 1'b0;
      d0 = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
      d1 = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
      d2 = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
      do_instr(op, d0, d1, d2, 1'($urandom), 1'($urandom));
    end

    // Fetch timeout -> sticky FAULT
    prev_ir = ir;
    for (int k = 0; k <= TIMEOUT; k++) begin
      imem_ack = 1'b0;
      instr    = 16'($urandom);
      dmem_ack = 1'($urandom);
      #1;
      chk("to_state", 16'(state), 16'd0);
      chk("to_imem_req", 16'(imem_req), 16'd1);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      #1;
      chk("fault_state", 16'(state), 16'd7);
      chk("fault_flag", 16'(fault), 16'd1);
      chk("fault_reqs", 16'({imem_req, dmem_req}), 16'd0);
      chk("fault_strobes", 16'(strobes()), 16'd0);
      chk("fault_ir", ir, prev_ir);
      @(negedge clk);
    end
    do_reset();

    // Reset asserted mid-EXEC while the M read is pending
    instr = 16'hFC10; imem_ack = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_exec_state", 16'(state), 16'd2);
    chk("mid_exec_dmem_req", 16'(dmem_req), 16'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dmem_req", 16'(dmem_req), 16'd0);
    chk("async_state", 16'(state), 16'd0);
    chk("async_ir", ir, 16'h0000);
    chk("async_fault", 16'(fault), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_state", 16'(state), 16'd0);
    chk("post_rst_ir", ir, 16'h0000);
    chk("post_rst_imem_req", 16'(imem_req), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hack_seq_ctrl.md
Name: hack_seq_ctrl

Overview:
- Multi-cycle control sequencer for the Hack-style 16-bit CPU datapath: the instruction decoder, A/D registers, A/M operand mux, ALU and PC.
- Fetches an instruction over an instruction-memory handshake and holds it in an internal instruction register.
- Steps each instruction through DECODE, EXEC and WB, driving register load enables, mux selects, PC control and data-memory handshakes from the latched instruction and the ALU flags.
- Detects stalled memory handshakes and enters a sticky FAULT state.

Parameters:
- TIMEOUT, 15: max cycles a request may wait for its ack before FAULT; range 1..255.
- CNT_W, 8: width of the internal wait counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr  input  16  instruction memory read data
- imem_req  output  1  instruction fetch request
- imem_ack  input  1  fetch complete; instr valid this cycle
- dmem_req  output  1  data memory request
- dmem_we  output  1  data memory write (1) / read (0)
- dmem_ack  input  1  data access complete
- zr  input  1  ALU output zero flag
- ng  input  1  ALU output negative flag
- ir  output  16  latched instruction register
- a_src_alu  output  1  A-register input mux: 1 = ALU out, 0 = ir
- am_sel  output  1  ALU y operand: 1 = M, 0 = A (ir[12] for C-instr, else 0)
- load_a  output  1  A register load strobe
- load_d  output  1  D register load strobe
- load_pc  output  1  PC load from A (jump taken)
- inc_pc  output  1  PC increment
- state  output  3  current state, debug
- fault  output  1  sticky handshake-timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; ir=16'h0000; fault=0; wait counter=0.
  - All strobes and requests are 0.
- Reset mid-operation aborts any request immediately; no pending strobe survives.
- State encoding: FETCH=0, DECODE=1, EXEC=2, WB=3, FAULT=7.
- FETCH:
  - imem_req=1 and held until imem_ack.
  - In the imem_ack cycle, ir<=instr at the clock edge; next state is DECODE.
- DECODE: one cycle; no requests; next state is EXEC.
- EXEC:
  - If ir[15]=1 and ir[12]=1 (M operand): dmem_req=1, dmem_we=0, held until dmem_ack, then go to WB.
  - Otherwise: a single cycle, then go to WB.
- WB, A-instruction (ir[15]=0):
  - One cycle: load_a=1, a_src_alu=0, inc_pc=1; then go to FETCH.
- WB, C-instruction (ir[15]=1):
  - dest bits: ir[5]=A, ir[4]=D, ir[3]=M.
  - If ir[3]=1: dmem_req=1, dmem_we=1, held until dmem_ack.
  - Strobes fire only in the WB exit cycle (the ack cycle, or the single WB cycle when ir[3]=0): load_a=ir[5] with a_src_alu=1, load_d=ir[4], and the PC strobe.
  - After the exit cycle, go to FETCH.
- Jump evaluation uses zr/ng sampled in the WB exit cycle:
  - jump = (ir[2]&ng) | (ir[1]&zr) | (ir[0]&~ng&~zr).
  - load_pc=jump, inc_pc=~jump.
- PC strobes: exactly one of load_pc/inc_pc pulses, once per completed instruction; they are never both high.
- am_sel = ir[15]&ir[12] in EXEC and WB, else 0.
- Wait counter:
  - Cleared on entering any waiting state and on every ack.
  - Increments each cycle a request is high without ack.
  - When count reaches TIMEOUT with no ack, go to FAULT.
  - An ack arriving in the same cycle the count reaches TIMEOUT wins: normal transition, no fault.
- FAULT:
  - fault=1; all requests and strobes are 0; state is held until reset.
  - ir retains its last value.
- Spurious acks (imem_ack outside FETCH, dmem_ack with dmem_req=0) are ignored.
- Latency:
  - A-instruction with zero-wait acks: 4 cycles.
  - C-instruction with M read and M write, zero-wait acks: 4 cycles.
  - Each wait cycle adds 1 cycle.

Test Plan:
- Reset, then instr=16'h0005 with imem_ack in the first FETCH cycle -> ir=16'h0005; in WB cycle 4, load_a=1, a_src_alu=0, inc_pc=1; load_pc=0; back to FETCH at cycle 5.
- instr=16'hFC10 (D=M), dmem_ack delayed 3 cycles -> EXEC holds dmem_req=1, dmem_we=0 for 4 cycles; in WB, load_d=1, load_a=0, inc_pc=1.
- instr=16'hE308 (M=D, dest M only), dmem_ack after 2 cycles -> WB holds dmem_req=1, dmem_we=1 for 3 cycles; no load_a/load_d; inc_pc pulses once, in the ack cycle.
- instr=16'hE301 (JGT), with zr=0/ng=0 and then zr=1 -> load_pc=1 in the first case; inc_pc=1 in the second. Repeat with jump field 3'b111 -> load_pc=1 regardless of flags.
- imem_ack withheld with TIMEOUT=15 -> FAULT after 15 wait cycles, fault=1, state=7, imem_req=0. Ack exactly at count 15 -> no fault.
- Assert rst_n low mid-EXEC while dmem_req=1 -> dmem_req drops without waiting for a clock edge; after release, state=FETCH, ir=0, fault=0.
